// File: rtl/gun_flash_sequencer_pkg.sv
// Shared definitions for the light-gun flash sequencer and the trigger logic
// that samples the photodetector. The trigger side derives its evaluation
// delay from the same frame-count defaults used here.
package gun_flash_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    BLACK = 2'd2,
    WHITE = 2'd3
  } flash_state_t;

  localparam int DEF_PRE_FRAMES   = 8;
  localparam int DEF_BLACK_FRAMES = 1;
  localparam int DEF_WHITE_FRAMES = 2;

  // Frames from shot until the first white frame: when the trigger logic
  // should start looking at the photodetector.
  localparam int EVAL_DELAY_FRAMES = DEF_PRE_FRAMES + DEF_BLACK_FRAMES;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gun_flash_sequencer_flash_frame_counter.sv
// Frame counter for the flash sequencer: clears on request, counts new_frame
// pulses, and flags the pulse that completes the current phase against a
// runtime limit.
module flash_frame_counter
  import gun_flash_sequencer_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         count_en,
  input  logic [W-1:0] limit,
  output logic         terminal
);

  logic [W-1:0] count;

  // Clear has priority so the phase change and the restart happen together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = count_en && (count == limit - 1'b1);

endmodule

// File: rtl/gun_flash_sequencer.sv
// Screen-side light-gun flash sequencer. On an accepted shot it locks input,
// waits PRE_FRAMES frames, forces BLACK_FRAMES all-black frames, then
// WHITE_FRAMES target-only frames. In mouse mode the timing and lock are the
// same but no flash is drawn.
// Optional feature: define GUN_AMBIENT_CHECK_EN to enable the sticky
// ambient_fault flag (light sensed at the end of a black frame).
module gun_flash_sequencer
  import gun_flash_sequencer_pkg::*;
#(
  parameter int PRE_FRAMES   = DEF_PRE_FRAMES,
  parameter int BLACK_FRAMES = DEF_BLACK_FRAMES,
  parameter int WHITE_FRAMES = DEF_WHITE_FRAMES
) (
  input  logic clk,
  input  logic rst,
  input  logic new_frame,
  input  logic shot_fired,
  input  logic gun_is_connected,
  input  logic gun_photodetector,
  output logic lock,
  output logic flash_black,
  output logic flash_target,
  output logic busy,
  output logic ambient_fault
);

  localparam int CW = $clog2(max3(PRE_FRAMES, BLACK_FRAMES, WHITE_FRAMES) + 1);

  flash_state_t  state;
  logic          gun_mode;
  logic [CW-1:0] limit;
  logic          terminal;
  logic          cnt_clear;
  logic          cnt_en;

  // Phase length for the running phase; IDLE never counts.
  always_comb begin
    limit = CW'(PRE_FRAMES);
    case (state)
      BLACK:   limit = CW'(BLACK_FRAMES);
      WHITE:   limit = CW'(WHITE_FRAMES);
      default: limit = CW'(PRE_FRAMES);
    endcase
  end

  // A new_frame arriving with the accepting shot is not counted because the
  // counter is held clear while IDLE.
  assign cnt_en    = new_frame && (state != IDLE);
  assign cnt_clear = (state == IDLE) || terminal;

  flash_frame_counter #(
    .W (CW)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .count_en (cnt_en),
    .limit    (limit),
    .terminal (terminal)
  );

  // Sequencer FSM; outputs are registered alongside each state transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      gun_mode     <= 1'b0;
      lock         <= 1'b0;
      busy         <= 1'b0;
      flash_black  <= 1'b0;
      flash_target <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (shot_fired) begin
            state    <= PRE;
            gun_mode <= gun_is_connected;
            lock     <= 1'b1;
            busy     <= 1'b1;
          end
        end
        PRE: begin
          if (terminal) begin
            state       <= BLACK;
            flash_black <= gun_mode;
          end
        end
        BLACK: begin
          if (terminal) begin
            state        <= WHITE;
            flash_black  <= 1'b0;
            flash_target <= gun_mode;
          end
        end
        WHITE: begin
          if (terminal) begin
            state        <= IDLE;
            flash_target <= 1'b0;
            lock         <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef GUN_AMBIENT_CHECK_EN
  // Sticky ambient-light flag: sampled on the closing cycle of each black
  // frame, cleared only by reset or the next accepted shot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ambient_fault <= 1'b0;
    end else if ((state == IDLE) && shot_fired) begin
      ambient_fault <= 1'b0;
    end else if ((state == BLACK) && new_frame && gun_mode && gun_photodetector) begin
      ambient_fault <= 1'b1;
    end
  end
`else
  logic unused_photodetector;
  assign unused_photodetector = gun_photodetector;
  assign ambient_fault        = 1'b0;
`endif

endmodule

// File: tb/tb_gun_flash_sequencer.sv
// Directed bench for gun_flash_sequencer with default frame counts
// (8 pre, 1 black, 2 white) and 100-cycle frames.
module tb_gun_flash_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic new_frame;
  logic shot_fired;
  logic gun_is_connected;
  logic gun_photodetector;
  logic lock;
  logic flash_black;
  logic flash_target;
  logic busy;
  logic ambient_fault;

  int total = 0;
  int bad   = 0;

`ifdef GUN_AMBIENT_CHECK_EN
  localparam bit AMB_ON = 1'b1;
`else
  localparam bit AMB_ON = 1'b0;
`endif

  gun_flash_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .new_frame         (new_frame),
    .shot_fired        (shot_fired),
    .gun_is_connected  (gun_is_connected),
    .gun_photodetector (gun_photodetector),
    .lock              (lock),
    .flash_black       (flash_black),
    .flash_target      (flash_target),
    .busy              (busy),
    .ambient_fault     (ambient_fault)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  // One complete shot sequence. extra: second shots in PRE and WHITE plus a
  // gun_is_connected change; abort_at: frame after which rst is pulsed.
  task automatic run_seq(input bit gun, input bit pd, input bit coincident,
                         input bit extra, input int abort_at);
    logic e_lock, e_black, e_target, e_amb;
    gun_is_connected  = gun;
    gun_photodetector = pd;
    check("idle_lock", lock, 1'b0);
    check("idle_busy", busy, 1'b0);
    shot_fired = 1'b1;
    new_frame  = coincident;
    step(1);
    shot_fired = 1'b0;
    new_frame  = 1'b0;
    check("shot_lock", lock, 1'b1);
    check("shot_busy", busy, 1'b1);
    check("shot_black", flash_black, 1'b0);
    check("shot_amb_clear", ambient_fault, 1'b0);
    step(99);
    for (int k = 1; k <= 11; k++) begin
      new_frame = 1'b1;
      step(1);
      new_frame = 1'b0;
      e_lock   = (k < 11);
      e_black  = gun && (k == 8);
      e_target = gun && (k == 9 || k == 10);
      e_amb    = AMB_ON && gun && pd && (k >= 9);
      check($sformatf("lock_f%0d", k), lock, e_lock);
      check($sformatf("busy_f%0d", k), busy, e_lock);
      check($sformatf("black_f%0d", k), flash_black, e_black);
      check($sformatf("target_f%0d", k), flash_target, e_target);
      check($sformatf("amb_f%0d", k), ambient_fault, e_amb);
      check($sformatf("excl_f%0d", k), flash_black & flash_target, 1'b0);
      if (abort_at == k) begin
        step(3);
        #2 rst = 1'b0;
        #1;
        check("abort_lock", lock, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_black", flash_black, 1'b0);
        check("abort_target", flash_target, 1'b0);
        check("abort_amb", ambient_fault, 1'b0);
        return;
      end
      if (extra && (k == 3 || k == 9)) begin
        step(40);
        shot_fired       = 1'b1;
        gun_is_connected = ~gun;
        step(1);
        shot_fired = 1'b0;
        check($sformatf("reshot_lock_f%0d", k), lock, 1'b1);
        step(58);
      end else begin
        step(99);
      end
    end
  endtask

  initial begin
    rst               = 1'b1;
    new_frame         = 1'b0;
    shot_fired        = 1'b0;
    gun_is_connected  = 1'b1;
    gun_photodetector = 1'b0;
    #3 rst = 1'b0;
    #1;
    check("rst_lock", lock, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_black", flash_black, 1'b0);
    check("rst_target", flash_target, 1'b0);
    check("rst_amb", ambient_fault, 1'b0);
    step(2);
    rst = 1'b1;
    step(2);

    run_seq(1'b1, 1'b0, 1'b0, 1'b0, 0);   // gun mode
    step(7);
    run_seq(1'b0, 1'b1, 1'b0, 1'b0, 0);   // mouse mode, light present
    step(7);
    run_seq(1'b1, 1'b0, 1'b0, 1'b1, 0);   // ignored extra shots
    step(7);
    run_seq(1'b1, 1'b0, 1'b1, 1'b0, 0);   // shot with coincident new_frame
    step(7);
    run_seq(1'b1, 1'b1, 1'b0, 1'b0, 0);   // light during black frame
    step(7);
    check("amb_sticky_idle", ambient_fault, AMB_ON);
    run_seq(1'b1, 1'b0, 1'b0, 1'b0, 0);   // next shot clears the flag
    step(7);
    run_seq(1'b1, 1'b1, 1'b0, 1'b0, 10);  // reset during WHITE
    step(2);
    rst = 1'b1;
    step(3);
    check("post_rst_lock", lock, 1'b0);
    run_seq(1'b1, 1'b0, 1'b0, 1'b0, 0);   // full sequence after reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gun_flash_sequencer.md
# gun_flash_sequencer

Drives the screen-side half of the light-gun detection protocol. On a shot pulse from the trigger logic it holds the input lock, waits a settle interval, and forces one or more all-black frames followed by one or more frames with only the target drawn white. The photodetector in the gun sees that pattern, and the trigger logic samples it. Sits between the trigger/input governor and the draw pipeline's final colour mux.

## Interface
- PRE_FRAMES, default 8: frames between shot and first black frame (≥1).
- BLACK_FRAMES, default 1: consecutive forced-black frames (≥1).
- WHITE_FRAMES, default 2: consecutive target-white frames (≥1).
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, asynchronous, active-low.
- new_frame  in  1  one-cycle pulse at start of each frame.
- shot_fired  in  1  one-cycle shot pulse from the trigger logic.
- gun_is_connected  in  1  1 = light gun active, 0 = mouse input.
- gun_photodetector  in  1  gun light sensor, used only by the optional ambient check.
- lock  out  1  high while a sequence is running; blocks further shots.
- flash_black  out  1  colour mux forces the whole frame to black.
- flash_target  out  1  colour mux draws the target box white and everything else black.
- busy  out  1  state ≠ IDLE.
- ambient_fault  out  1  sticky flag; light was sensed during a black frame (optional).

## Operation
- FSM states: IDLE, PRE, BLACK, WHITE.
- Frame counter width: $clog2(max(PRE_FRAMES, BLACK_FRAMES, WHITE_FRAMES)+1).
- **IDLE**
  - On shot_fired: go to PRE, clear the counter, latch gun_is_connected into gun_mode.
  - shot_fired in any other state is ignored.
- **PRE**
  - Each new_frame increments the counter.
  - A new_frame with counter == PRE_FRAMES−1 goes to BLACK and clears the counter.
- **BLACK**
  - Same rule with BLACK_FRAMES; the exit goes to WHITE.
- **WHITE**
  - Same rule with WHITE_FRAMES; the exit goes to IDLE.
- Outputs:
  - lock = busy = (state ≠ IDLE).
  - flash_black = (state == BLACK) & gun_mode.
  - flash_target = (state == WHITE) & gun_mode.
- Mouse mode (gun_mode = 0): identical timing and lock, flash outputs stay 0.
- The flash outputs are never both high.
- shot_fired and new_frame in the same cycle while IDLE: enter PRE. That new_frame is not counted.
- A change of gun_is_connected mid-sequence has no effect until the next shot.

## Timing
- Reset (rst low, asynchronous): state = IDLE, counter = 0, gun_mode = 0. All outputs are 0.
- Release is synchronous to clk.
- All outputs are registered and change on the clk edge after the triggering input pulse (one-cycle latency).
- lock rises 1 cycle after shot_fired.
- flash_black rises 1 cycle after the PRE_FRAMES-th counted new_frame.
- flash_black lasts exactly BLACK_FRAMES frame periods.
- flash_target follows with no gap and lasts WHITE_FRAMES frame periods.
- lock and busy fall in the same cycle that flash_target falls.
- Total locked duration: PRE_FRAMES + BLACK_FRAMES + WHITE_FRAMES frames.
- Reset asserted mid-sequence: all outputs drop immediately and the sequence is aborted.

## Configuration
- Macro: GUN_AMBIENT_CHECK_EN.
- When defined:
  - On the last clk cycle of each BLACK frame (the cycle new_frame is high in BLACK), with gun_mode = 1, gun_photodetector = 1 sets ambient_fault.
  - ambient_fault stays set until reset or the next shot accepted in IDLE.
- When undefined: ambient_fault is tied to 0 and gun_photodetector is unused.

## Structure
- A shared package holds:
  - the state typedef (enum logic [1:0] IDLE/PRE/BLACK/WHITE);
  - default frame-count constants, shared with the trigger logic so its evaluation delay is derived from PRE_FRAMES + BLACK_FRAMES.
- One sub-module, flash_frame_counter: loadable/clearable counter that counts on new_frame and flags terminal count against a runtime limit.

## Test plan
- Gun mode, defaults: shot_fired at cycle 5, then new_frame every 100 cycles.
  - lock goes high at cycle 6.
  - flash_black is high for exactly 1 frame after the 8th new_frame.
  - flash_target is high for the next 2 frames.
  - lock falls with flash_target.
- Mouse mode (gun_is_connected = 0): same stimulus gives identical lock timing, with flash_black and flash_target staying 0 throughout.
- A second shot_fired during PRE and another during WHITE: no restart, and total lock length is still 11 frames.
- shot_fired coincident with new_frame in IDLE: flash_black begins after 8 further new_frame pulses.
- rst pulsed low during WHITE: all outputs are 0 asynchronously, state is IDLE, and the next shot runs a full sequence.
- With GUN_AMBIENT_CHECK_EN defined:
  - photodetector held at 1 during BLACK sets ambient_fault, which clears on the next accepted shot.
  - photodetector held at 0 leaves ambient_fault at 0.
